// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and limits for the parametrised SPI master and its helpers.
//   spi_state_e : transfer FSM states (IDLE, SETUP, XFER, HOLD, DONE)
//   spi_mode_t  : SPI mode pair {cpol, cpha}
//   MAX_DATA_W / MAX_NUM_CS : upper bounds used to validate parameters
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int MAX_DATA_W = 32;
    localparam int MAX_NUM_CS = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_master_param_if.sv
// -----------------------------------------------------------------------------
// spi_master_param_if
// Host handshake plus SPI pin bundle for spi_master_param.
//   Host side : start, tx_data, cs_sel, clk_div, cpol, cpha -> busy, done, rx_data
//   Pin side  : miso -> sclk, mosi, cs_n
// Optional macro SPI_LSB_FIRST_EN adds the lsb_first configuration input.
// modport master : the SPI master's view; modport slave : the opposite view.
// -----------------------------------------------------------------------------
interface spi_master_param_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [CS_W-1:0]   cs_sel;
    logic [DIV_W-1:0]  clk_div;
    logic              cpol;
    logic              cpha;
`ifdef SPI_LSB_FIRST_EN
    logic              lsb_first;
`endif
    logic              miso;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              sclk;
    logic              mosi;
    logic [NUM_CS-1:0] cs_n;

`ifdef SPI_LSB_FIRST_EN
    modport master (
        input  start, tx_data, cs_sel, clk_div, cpol, cpha, lsb_first, miso,
        output busy, done, rx_data, sclk, mosi, cs_n
    );
    modport slave (
        output start, tx_data, cs_sel, clk_div, cpol, cpha, lsb_first, miso,
        input  busy, done, rx_data, sclk, mosi, cs_n
    );
`else
    modport master (
        input  start, tx_data, cs_sel, clk_div, cpol, cpha, miso,
        output busy, done, rx_data, sclk, mosi, cs_n
    );
    modport slave (
        output start, tx_data, cs_sel, clk_div, cpol, cpha, miso,
        input  busy, done, rx_data, sclk, mosi, cs_n
    );
`endif

endinterface

// File: rtl/spi_clk_tick.sv
// -----------------------------------------------------------------------------
// spi_clk_tick
// Reloadable down-counter producing a one-cycle tick every i_div+1 enabled
// cycles. Reusable for SCLK generation and for slave-side oversampling.
//   clk, reset : system clock, synchronous active-high reset
//   i_load     : force-load the counter with i_div (priority over i_en)
//   i_en       : count enable; the counter reloads from i_div when it ticks
//   i_div      : reload value
//   o_tick     : high for one cycle while enabled and the count is zero
// -----------------------------------------------------------------------------
module spi_clk_tick #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);
    localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;

    assign o_tick = i_en & (r_cnt == '0);

    // Down-counter: load, reload on zero, otherwise decrement while enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_div;
        end else if (i_en) begin
            if (r_cnt == '0) begin
                r_cnt <= i_div;
            end else begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// -----------------------------------------------------------------------------
// spi_master_param
// Parametrised SPI master: runtime CPOL/CPHA, programmable SCLK divider,
// DATA_W-bit transfers, one-hot active-low chip selects for NUM_CS slaves.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : spi_master_param_if.master (host handshake + SPI pins)
// Optional macro SPI_LSB_FIRST_EN: adds bus.lsb_first, latched on start;
// when set, bit 0 goes out first and rx_data is returned in natural order.
// The interface instance must carry the same DATA_W/NUM_CS/DIV_W values.
// -----------------------------------------------------------------------------
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    spi_master_param_if.master bus
);
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);
    localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);

    // Reject out-of-range parameters at elaboration.
    if (DATA_W < 2 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
        $error("spi_master_param: DATA_W out of range");
    end
    if (NUM_CS < 1 || NUM_CS > MAX_NUM_CS) begin : g_bad_num_cs
        $error("spi_master_param: NUM_CS out of range");
    end

    // Active-low one-hot decode; selects beyond NUM_CS leave every line high.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        for (int i = 0; i < NUM_CS; i++) begin
            v[i] = (sel != CS_W'(i));
        end
        return v;
    endfunction

    function automatic logic next_bit(input logic [DATA_W-1:0] sh, input logic lsb);
        return lsb ? sh[0] : sh[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] sh, input logic lsb);
        return lsb ? {1'b0, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], 1'b0};
    endfunction

    // LSB-first words fill from the top so the final word is in natural order.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sh, input logic lsb,
                                                   input logic b);
        return lsb ? {b, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], b};
    endfunction

    spi_state_e        r_state;
    spi_mode_t         r_mode;
    logic [DIV_W-1:0]  r_div;
    logic [DATA_W-1:0] r_tx_sh;
    logic [DATA_W-1:0] r_rx_sh;
    logic [EDGE_W-1:0] r_edge_cnt;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_sclk;
    logic              r_mosi;
    logic [NUM_CS-1:0] r_cs_n;

    logic              w_accept;
    logic              w_tick;
    logic              w_tick_en;
    logic [DIV_W-1:0]  w_div;
    logic              w_lsb_in;
    logic              w_lsb;
    logic              w_leading;
    logic              w_sample;
    logic              w_last_edge;

`ifdef SPI_LSB_FIRST_EN
    logic r_lsb;
    assign w_lsb_in = bus.lsb_first;
    assign w_lsb    = r_lsb;

    // Bit-order selection is latched with the rest of the configuration.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lsb <= 1'b0;
        end else if (w_accept) begin
            r_lsb <= bus.lsb_first;
        end else begin
            r_lsb <= r_lsb;
        end
    end
`else
    assign w_lsb_in = 1'b0;
    assign w_lsb    = 1'b0;
`endif

    assign w_accept    = bus.start & ((r_state == IDLE) | (r_state == DONE));
    assign w_tick_en   = (r_state == SETUP) | (r_state == XFER) | (r_state == HOLD);
    assign w_div       = w_accept ? bus.clk_div : r_div;
    // Even edge indices move sclk away from cpol (leading edges).
    assign w_leading   = (r_edge_cnt[0] == 1'b0);
    assign w_sample    = r_mode.cpha ? ~w_leading : w_leading;
    assign w_last_edge = (r_edge_cnt == LAST_EDGE);

    spi_clk_tick #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_accept),
        .i_en   (w_tick_en),
        .i_div  (w_div),
        .o_tick (w_tick)
    );

    // Transfer FSM with registered outputs, shift registers and CS decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_mode     <= '0;
            r_div      <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_edge_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rx_data  <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= '1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    r_sclk <= bus.cpol;
                    r_busy <= 1'b0;
                    r_cs_n <= '1;
                    if (bus.start) begin
                        r_state    <= SETUP;
                        r_busy     <= 1'b1;
                        r_cs_n     <= cs_decode(bus.cs_sel);
                        r_mode     <= '{cpol: bus.cpol, cpha: bus.cpha};
                        r_div      <= bus.clk_div;
                        r_edge_cnt <= '0;
                        r_rx_sh    <= '0;
                        // CPHA=0 presents the first bit before the first edge.
                        if (!bus.cpha) begin
                            r_mosi  <= next_bit(bus.tx_data, w_lsb_in);
                            r_tx_sh <= shift_out(bus.tx_data, w_lsb_in);
                        end else begin
                            r_tx_sh <= bus.tx_data;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_tick) begin
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= r_edge_cnt + EDGE_ONE;
                        if (w_sample) begin
                            r_rx_sh <= shift_in(r_rx_sh, w_lsb, bus.miso);
                        end else if (!w_last_edge) begin
                            r_mosi  <= next_bit(r_tx_sh, w_lsb);
                            r_tx_sh <= shift_out(r_tx_sh, w_lsb);
                        end
                        if (w_last_edge) begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    r_sclk <= r_mode.cpol;
                    if (w_tick) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_rx_data <= r_rx_sh;
                        r_cs_n    <= '1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_cs_n  <= '1;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx_data;
    assign bus.sclk    = r_sclk;
    assign bus.mosi    = r_mosi;
    assign bus.cs_n    = r_cs_n;

endmodule

// File: tb/tb_spi_master_param.sv
// -----------------------------------------------------------------------------
// tb_spi_master_param
// Directed and randomised transfers against a behavioural SPI slave model.
// Expected values come from SPI mode rules: the slave shifts its word out on
// the non-sampling edges, mosi is collected on the sampling edges, and busy
// length / edge counts follow from the divider and word width.
// -----------------------------------------------------------------------------
module tb_spi_master_param;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_master_param_if #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) bus ();
    spi_master_param #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    spi_master_param_if #(.DATA_W(8), .NUM_CS(3), .DIV_W(8)) bus3 ();
    spi_master_param #(.DATA_W(8), .NUM_CS(3), .DIV_W(8)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    int checks = 0;
    int errors = 0;
    bit eff_lsb = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Position in the word of the k-th bit on the wire.
    function automatic int bit_pos(input int k);
        return eff_lsb ? k : W - 1 - k;
    endfunction

    // Drive configuration and raise start; call at a falling clock edge.
    task automatic launch(input logic [7:0] tx, input int cs, input logic [7:0] div,
                          input bit pol, input bit pha, input bit lsb);
        bus.tx_data = tx;
        bus.cs_sel  = 2'(cs);
        bus.clk_div = div;
        bus.cpol    = pol;
        bus.cpha    = pha;
`ifdef SPI_LSB_FIRST_EN
        bus.lsb_first = lsb;
        eff_lsb       = lsb;
`else
        eff_lsb       = 1'b0;
`endif
        bus.start = 1'b1;
    endtask

    // Follow one accepted transfer as the slave and check it at done.
    task automatic monitor(input string tag, input logic [7:0] tx, input logic [7:0] sw,
                           input int cs, input int div, input bit pol, input bit pha,
                           input int glitch_at, input bit chain,
                           input logic [7:0] ntx, input int ncs, input int ndiv,
                           input bit npol, input bit npha);
        logic [3:0] exp_cs;
        logic [7:0] got_mosi;
        logic       prev;
        bit         lead;
        bit         ok_cs;
        bit         seen_done;
        int         busy_cnt, rises, falls, mi, mo;
        exp_cs = 4'b1111;
        if (cs < 4) exp_cs[cs] = 1'b0;
        got_mosi = 8'h00;
        ok_cs = 1'b1; seen_done = 1'b0;
        busy_cnt = 0; rises = 0; falls = 0; mi = 0; mo = 0;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_entry_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_entry_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_entry_sclk"}, 32'(bus.sclk), 32'(pol));
        if (!pha) chk({tag, "_first_mosi"}, 32'(bus.mosi), 32'(tx[bit_pos(0)]));
        prev = pol;
        if (!pha) begin
            bus.miso = sw[bit_pos(0)];
            mi = 1;
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (bus.done === 1'b1) begin
                seen_done = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.cs_n !== exp_cs) ok_cs = 1'b0;
            if (bus.sclk !== prev) begin
                lead = (bus.sclk !== pol);
                if (bus.sclk === 1'b1) rises++; else falls++;
                if (lead ^ pha) begin
                    if (mo < W) got_mosi[bit_pos(mo)] = bus.mosi;
                    mo++;
                end else if (mi < W) begin
                    bus.miso = sw[bit_pos(mi)];
                    mi++;
                end
                prev = bus.sclk;
            end
            bus.start = (cyc == glitch_at);
            if (cyc == glitch_at) begin
                bus.tx_data = 8'h11;
                bus.cs_sel  = ~bus.cs_sel;
                bus.clk_div = 8'd0;
            end
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        chk({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_rx_data"}, 32'(bus.rx_data), 32'(sw));
        chk({tag, "_done_cs_n"}, 32'(bus.cs_n), 32'hF);
        chk({tag, "_done_sclk"}, 32'(bus.sclk), 32'(pol));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'((div + 1) * (2 * W + 2)));
        chk({tag, "_rises"}, 32'(rises), 32'(W));
        chk({tag, "_falls"}, 32'(falls), 32'(W));
        chk({tag, "_mosi_word"}, 32'(got_mosi), 32'(tx));
        chk({tag, "_cs_n_during"}, 32'(ok_cs), 32'd1);
        if (chain) begin
            launch(ntx, ncs, 8'(ndiv), npol, npha, 1'b0);
        end else begin
            @(negedge clk);
            chk({tag, "_after_done"}, 32'(bus.done), 32'd0);
            chk({tag, "_after_busy"}, 32'(bus.busy), 32'd0);
            chk({tag, "_idle_sclk"}, 32'(bus.sclk), 32'(pol));
        end
    endtask

    initial begin
        logic [7:0] tx, sw, ntx;
        logic       prev_s;
        int         edges_s, cs, div;
        bit         pol, pha, lsb, ok3, seen3;
        int         busy3;

        reset = 1'b1;
        bus.start = 1'b0; bus.tx_data = 8'h00; bus.cs_sel = 2'd0; bus.clk_div = 8'd0;
        bus.cpol = 1'b0; bus.cpha = 1'b0; bus.miso = 1'b0;
        bus3.start = 1'b0; bus3.tx_data = 8'h00; bus3.cs_sel = 2'd0; bus3.clk_div = 8'd0;
        bus3.cpol = 1'b0; bus3.cpha = 1'b0; bus3.miso = 1'b0;
`ifdef SPI_LSB_FIRST_EN
        bus.lsb_first = 1'b0;
        bus3.lsb_first = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_rx", 32'(bus.rx_data), 32'd0);
        chk("rst_sclk", 32'(bus.sclk), 32'd0);
        chk("rst_mosi", 32'(bus.mosi), 32'd0);
        chk("rst_cs_n", 32'(bus.cs_n), 32'hF);
        reset = 1'b0;
        @(negedge clk);

        // Mode 0, divider 1.
        chk("m0_idle_sclk", 32'(bus.sclk), 32'd0);
        launch(8'hA5, 0, 8'd1, 1'b0, 1'b0, 1'b0);
        monitor("m0", 8'hA5, 8'h3C, 0, 1, 1'b0, 1'b0, -1, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0);

        // Mode 3, divider 0.
        launch(8'hF0, 1, 8'd0, 1'b1, 1'b1, 1'b0);
        monitor("m3", 8'hF0, 8'h0F, 1, 0, 1'b1, 1'b1, -1, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0);

        // Chip select 2 in mode 1.
        tx = 8'($urandom); sw = 8'($urandom);
        launch(tx, 2, 8'd2, 1'b0, 1'b1, 1'b0);
        monitor("cs2", tx, sw, 2, 2, 1'b0, 1'b1, -1, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0);

        // Start during busy is ignored; start in the done cycle chains.
        tx = 8'($urandom); sw = 8'($urandom); ntx = 8'($urandom);
        launch(tx, 3, 8'd1, 1'b1, 1'b0, 1'b0);
        monitor("ign", tx, sw, 3, 1, 1'b1, 1'b0, 5, 1'b1, ntx, 1, 0, 1'b0, 1'b0);
        sw = 8'($urandom);
        monitor("chain", ntx, sw, 1, 0, 1'b0, 1'b0, -1, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0);

        // Reset during the transfer, around bit 4.
        launch(8'hC3, 0, 8'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        prev_s = bus.sclk;
        edges_s = 0;
        for (int c = 0; c < 200 && edges_s < 9; c++) begin
            @(negedge clk);
            if (bus.sclk !== prev_s) begin
                edges_s++;
                prev_s = bus.sclk;
            end
        end
        chk("abort_reach_bit4", 32'(edges_s), 32'd9);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_cs_n", 32'(bus.cs_n), 32'hF);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_sclk", 32'(bus.sclk), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_rx", 32'(bus.rx_data), 32'd0);
        ok3 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) ok3 = 1'b0;
        end
        chk("abort_quiet", 32'(ok3), 32'd1);
        sw = 8'($urandom);
        launch(8'h5A, 0, 8'd1, 1'b0, 1'b0, 1'b0);
        monitor("post_abort", 8'h5A, sw, 0, 1, 1'b0, 1'b0, -1, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0);

        // Randomised transfers over modes, dividers and selects.
        for (int n = 0; n < 6; n++) begin
            tx  = 8'($urandom);
            sw  = 8'($urandom);
            cs  = int'($urandom_range(0, 3));
            div = int'($urandom_range(0, 3));
            pol = 1'($urandom_range(0, 1));
            pha = 1'($urandom_range(0, 1));
            lsb = 1'($urandom_range(0, 1));
            launch(tx, cs, 8'(div), pol, pha, lsb);
            monitor($sformatf("rnd%0d", n), tx, sw, cs, div, pol, pha, -1, 1'b0,
                    8'h00, 0, 0, 1'b0, 1'b0);
        end

`ifdef SPI_LSB_FIRST_EN
        // LSB-first: bit 0 leaves first, received word comes back natural.
        launch(8'h01, 0, 8'd1, 1'b0, 1'b0, 1'b1);
        monitor("lsb", 8'h01, 8'h80, 0, 1, 1'b0, 1'b0, -1, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0);
`endif

        // Three-slave master, select beyond the decoded range.
        bus3.tx_data = 8'h69; bus3.cs_sel = 2'd3; bus3.clk_div = 8'd0;
        bus3.cpol = 1'b0; bus3.cpha = 1'b0; bus3.miso = 1'b1; bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        ok3 = 1'b1; seen3 = 1'b0; busy3 = 0;
        for (int c = 0; c < 500; c++) begin
            if (bus3.cs_n !== 3'b111) ok3 = 1'b0;
            if (bus3.done === 1'b1) begin
                seen3 = 1'b1;
                break;
            end
            if (bus3.busy === 1'b1) busy3++;
            @(negedge clk);
        end
        chk("cs3_cs_n_high", 32'(ok3), 32'd1);
        chk("cs3_done_seen", 32'(seen3), 32'd1);
        chk("cs3_rx", 32'(bus3.rx_data), 32'hFF);
        chk("cs3_busy_cycles", 32'(busy3), 32'd18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised next-generation SPI master that replaces the fixed 8-bit, mode-0, single-slave master in the SPI top.
- Runtime-selectable CPOL/CPHA (all four SPI modes).
- Programmable SCLK divider.
- Configurable data width.
- One-hot-decoded chip selects for NUM_CS slaves.
- start/busy/done handshake toward the host logic.
- Sits between host logic and the SPI pins; drives the slave models in the SPI top bench.

Parameters:
DATA_W, 8, bits per transfer (2..32)
NUM_CS, 4, number of chip-select outputs (1..16)
DIV_W, 8, width of the clk_div input

Ports:
clk  input  1  system clock, one clock domain; all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  request a transfer; sampled only in IDLE
tx_data  input  DATA_W  word to send; latched on accepted start
cs_sel  input  $clog2(NUM_CS) (min 1)  target slave; latched on accepted start
clk_div  input  DIV_W  half-period = clk_div+1 clk cycles; latched on accepted start
cpol  input  1  SCLK idle level; latched on accepted start
cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on accepted start
miso  input  1  serial data from slave
busy  output  1  transfer in progress
done  output  1  one-cycle pulse when a transfer completes
rx_data  output  DATA_W  received word; updated at done, held until the next done
sclk  output  1  SPI clock
mosi  output  1  serial data to slave
cs_n  output  NUM_CS  active-low chip selects; at most one bit low

Behaviour:
- Reset values: busy=0, done=0, rx_data=0, sclk=0, mosi=0, cs_n=all 1s, FSM=IDLE. Reset mid-transfer aborts immediately; no done pulse is generated.
- Bit order is MSB first unless the optional feature is enabled.
- Half-period tick: a counter reloads to the latched clk_div and ticks when it reaches 0, so each phase lasts D+1 cycles (D = latched clk_div). clk_div=0 gives SCLK = clk/2.
- IDLE:
  - sclk follows the registered cpol input.
  - A start accepted on cycle N latches tx_data, cs_sel, clk_div, cpol and cpha.
  - On cycle N+1: busy=1, cs_n[cs_sel]=0, state goes to SETUP.
  - start while busy is ignored and not queued.
- SETUP (D+1 cycles):
  - CPHA=0: mosi = first bit of tx_data.
  - CPHA=1: mosi holds its previous value.
- XFER (2*DATA_W half-periods):
  - sclk toggles on every tick.
  - CPHA=0: sample miso on the leading edge, shift mosi on the trailing edge.
  - CPHA=1: shift mosi on the leading edge, sample miso on the trailing edge.
  - "Leading" means the edge away from cpol.
  - A bit counter tracks edges; the last edge ends with sclk = cpol.
- HOLD (D+1 cycles): cs_n stays asserted and sclk = cpol, meeting the CS hold time.
- DONE (1 cycle):
  - busy=0, done=1, rx_data = shift register, cs_n = all 1s, back to IDLE.
  - A new start may be accepted in this same cycle.
- Total busy cycles per transfer = (D+1)*(2*DATA_W+2).
- cs_sel >= NUM_CS (non-power-of-two NUM_CS): the transfer still runs with all cs_n high; done pulses and rx_data is updated.
- Input changes during busy have no effect, because all configuration is latched.

Optional Feature:
SPI_LSB_FIRST_EN
- Defined: adds input port lsb_first (1 bit), latched on start. When lsb_first=1, bit 0 is shifted out first and received bits fill from the MSB downward, so rx_data comes out in natural order.
- Undefined: the port is absent and transfers are always MSB first.

Decomposition:
- Package spi_pkg:
  - spi_state_e enum: IDLE, SETUP, XFER, HOLD, DONE.
  - spi_mode_t struct: {cpol, cpha}.
  - Constants MAX_DATA_W=32 and MAX_NUM_CS=16, for parameter range assertions.
- Sub-module spi_clk_tick: DIV_W down-counter with load/enable, outputting a one-cycle tick. It is reusable by the future SPI slave oversampler.
- The FSM, shift registers and CS decode stay in spi_master_param.

Test Plan:
- Mode 0, DATA_W=8, clk_div=1, tx 0xA5, bench slave returns 0x3C:
  - mosi reads 1,0,1,0,0,1,0,1 on the sclk rising edges.
  - rx_data=0x3C at done; busy high for 36 cycles.
  - 8 rising plus 8 falling sclk edges; sclk idles low.
- Mode 3 (cpol=1, cpha=1), clk_div=0, tx 0xF0, slave returns 0x0F:
  - sclk idles high; data is sampled on rising edges.
  - rx_data=0x0F; busy high for 18 cycles.
- cs_sel=2, NUM_CS=4:
  - cs_n=4'b1011 from the cycle after start through HOLD, then 4'b1111 coincident with done.
  - With NUM_CS=3 and cs_sel=3: cs_n stays 3'b111 and done still pulses.
- start pulsed again 5 cycles into a transfer with new tx_data 0x11:
  - Ignored; the original word completes unchanged.
  - A start in the done cycle is accepted and busy reasserts on the next cycle.
- reset asserted mid-XFER (bit 4), held one cycle:
  - Next cycle: cs_n=all 1s, busy=0, sclk=0, no done pulse, rx_data=0.
  - A following transfer of 0x5A completes correctly.
- With SPI_LSB_FIRST_EN defined and lsb_first=1, tx 0x01:
  - mosi's first bit is 1.
  - Slave sends 0x80 LSB first; rx_data=0x80.
